// File: rtl/lmh6401_pkg.sv
// Shared definitions for the LMH6401 VGA gain path: register constants,
// the 16-bit SPI word layout and the clamping word builder.
package lmh6401_pkg;

  localparam logic [6:0] LMH6401_GAIN_REG  = 7'h02;
  localparam logic [5:0] LMH6401_MAX_ATTEN = 6'd32;

  typedef struct packed {
    logic       rw;
    logic [6:0] reg_addr;
    logic       rsvd;
    logic       pd;
    logic [5:0] atten;
  } lmh6401_word_t;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_ARB  = 2'd1,
    S_SEND = 2'd2
  } gain_state_e;

  // The device saturates above 32 dB, so larger requests are pinned there.
  function automatic lmh6401_word_t lmh6401_gain_word(input logic pd, input logic [5:0] atten);
    lmh6401_word_t w;
    w.rw       = 1'b0;
    w.reg_addr = LMH6401_GAIN_REG;
    w.rsvd     = 1'b0;
    w.pd       = pd;
    w.atten    = (atten > LMH6401_MAX_ATTEN) ? LMH6401_MAX_ATTEN : atten;
    return w;
  endfunction

endpackage

// File: rtl/lmh6401_gain_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping; the pointer moves past the winner when advance is asserted.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant_onehot,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q;
  logic          found;
  int            idx;

  always_comb begin
    grant_idx    = '0;
    grant_onehot = '0;
    found        = 1'b0;
    idx          = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = IW'(idx);
      end
    end
    if (found) grant_onehot = N'(1) << grant_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/lmh6401_gain_sched.sv
// Gain-write sequencer for a bank of LMH6401 VGAs: initialises every channel,
// then arbitrates per-channel gain requests onto a single SPI word port.
module lmh6401_gain_sched
  import lmh6401_pkg::*;
#(
  parameter int         NUM_CHANNELS   = 4,
  parameter logic [5:0] DEFAULT_ATTEN  = 6'd32,
  parameter bit         SKIP_REDUNDANT = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CHANNELS*6-1:0]       req_atten,
  input  logic [NUM_CHANNELS-1:0]         req_pd,
  input  logic [NUM_CHANNELS-1:0]         req_valid,
  output logic [NUM_CHANNELS-1:0]         req_ready,
  output logic [$clog2(NUM_CHANNELS)-1:0] spi_addr,
  output logic [15:0]                     spi_data,
  output logic                            spi_valid,
  input  logic                            spi_ready,
  output logic [NUM_CHANNELS*6-1:0]       shadow_atten,
  output logic                            init_done,
  output logic                            busy,
  output logic [1:0]                      dbg_state
);

  localparam int CW = $clog2(NUM_CHANNELS);
  localparam lmh6401_word_t INIT_WORD = lmh6401_gain_word(1'b0, DEFAULT_ATTEN);

  // Handshakes: a word transfers on a rising edge where spi_valid & spi_ready;
  // spi_addr/spi_data stay stable while spi_valid waits. A request transfers
  // on an edge where req_valid[g] & req_ready[g]; req_ready never looks at spi_ready.

  gain_state_e                state_q, state_d;
  logic [CW-1:0]              init_ch_q, init_ch_d;
  logic                       init_done_q, init_done_d;
  lmh6401_word_t              word_q, word_d;
  logic [CW-1:0]              addr_q, addr_d;
  logic [NUM_CHANNELS*6-1:0]  shadow_atten_q, shadow_atten_d;
  logic [NUM_CHANNELS-1:0]    shadow_pd_q, shadow_pd_d;

  logic [NUM_CHANNELS-1:0]    grant_onehot;
  logic [CW-1:0]              grant_idx;
  logic                       advance;
  lmh6401_word_t              gnt_word;
  logic                       gnt_redundant;
  logic                       spi_valid_c;
  logic [NUM_CHANNELS-1:0]    req_ready_c;

  rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
    .clk          (clk),
    .reset        (reset),
    .req          (req_valid),
    .advance      (advance),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  assign gnt_word = lmh6401_gain_word(req_pd[grant_idx], req_atten[int'(grant_idx)*6 +: 6]);
  assign gnt_redundant = SKIP_REDUNDANT &&
    ({gnt_word.pd, gnt_word.atten} ==
     {shadow_pd_q[grant_idx], shadow_atten_q[int'(grant_idx)*6 +: 6]});

  always_comb begin
    state_d        = state_q;
    init_ch_d      = init_ch_q;
    init_done_d    = init_done_q;
    word_d         = word_q;
    addr_d         = addr_q;
    shadow_atten_d = shadow_atten_q;
    shadow_pd_d    = shadow_pd_q;
    advance        = 1'b0;
    spi_valid_c    = 1'b0;
    spi_addr       = addr_q;
    spi_data       = word_q;
    req_ready_c    = '0;
    case (state_q)
      S_INIT: begin
        spi_valid_c = 1'b1;
        spi_addr    = init_ch_q;
        spi_data    = INIT_WORD;
        if (spi_ready) begin
          if (init_ch_q == CW'(NUM_CHANNELS - 1)) begin
            init_ch_d   = '0;
            init_done_d = 1'b1;
            state_d     = S_ARB;
          end else begin
            init_ch_d = init_ch_q + 1'b1;
          end
        end
      end
      S_ARB: begin
        if (|req_valid) begin
          req_ready_c = grant_onehot;
          advance     = 1'b1;
          word_d      = gnt_word;
          addr_d      = grant_idx;
          if (!gnt_redundant) state_d = S_SEND;
        end
      end
      S_SEND: begin
        spi_valid_c = 1'b1;
        if (spi_ready) begin
          shadow_atten_d[int'(addr_q)*6 +: 6] = word_q.atten;
          shadow_pd_d[addr_q]                 = word_q.pd;
          state_d                             = S_ARB;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Outputs are masked while reset is held so an in-flight word is dropped at once.
  assign spi_valid    = spi_valid_c & ~reset;
  assign req_ready    = reset ? '0 : req_ready_c;
  assign shadow_atten = shadow_atten_q;
  assign init_done    = init_done_q;
  assign busy         = (state_q != S_ARB) || (|req_valid);
  assign dbg_state    = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_INIT;
      init_ch_q      <= '0;
      init_done_q    <= 1'b0;
      word_q         <= INIT_WORD;
      addr_q         <= '0;
      shadow_atten_q <= {NUM_CHANNELS{INIT_WORD.atten}};
      shadow_pd_q    <= '0;
    end else begin
      state_q        <= state_d;
      init_ch_q      <= init_ch_d;
      init_done_q    <= init_done_d;
      word_q         <= word_d;
      addr_q         <= addr_d;
      shadow_atten_q <= shadow_atten_d;
      shadow_pd_q    <= shadow_pd_d;
    end
  end

endmodule

// File: tb/tb_lmh6401_gain_sched.sv
// Directed bench for lmh6401_gain_sched: a behavioural SPI-side responder
// acknowledges words with a fixed delay and a monitor logs words and grants.
module tb_lmh6401_gain_sched;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N*6-1:0] req_atten;
  logic [N-1:0]  req_pd, req_valid, req_ready;
  logic [1:0]    spi_addr;
  logic [15:0]   spi_data;
  logic          spi_valid, spi_ready;
  logic [N*6-1:0] shadow_atten;
  logic          init_done, busy;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];
  int          grant_q[$];
  int          valid_cycles = 0;
  bit          auto_ready = 1'b0;
  bit          hs_flag = 1'b0;
  int          wait_cnt = 0;

  lmh6401_gain_sched #(.NUM_CHANNELS(N), .DEFAULT_ATTEN(6'd32), .SKIP_REDUNDANT(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_atten    (req_atten),
    .req_pd       (req_pd),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .spi_addr     (spi_addr),
    .spi_data     (spi_data),
    .spi_valid    (spi_valid),
    .spi_ready    (spi_ready),
    .shadow_atten (shadow_atten),
    .init_done    (init_done),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

  // monitor: values seen just before the active edge are what the edge transfers
  always @(posedge clk) begin
    if (!reset) begin
      if (spi_valid && spi_ready) begin
        got_q.push_back({spi_addr, spi_data});
        hs_flag = 1'b1;
      end
      if (spi_valid) valid_cycles++;
      for (int i = 0; i < N; i++) if (req_ready[i]) grant_q.push_back(i);
    end
  end

  // SPI-side responder: ready after the word has been offered for two cycles
  always @(negedge clk) begin
    if (!auto_ready || !spi_valid || hs_flag) begin
      wait_cnt  = 0;
      spi_ready = 1'b0;
    end else begin
      wait_cnt++;
      spi_ready = (wait_cnt >= 2);
    end
    hs_flag = 1'b0;
  end

  // driver tasks
  task automatic do_req(input int ch, input logic [5:0] a, input logic pd, output bit ok);
    @(negedge clk);
    req_atten[ch*6 +: 6] = a;
    req_pd[ch]           = pd;
    req_valid[ch]        = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      #1;
      if (req_ready[ch]) ok = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    req_valid[ch] = 1'b0;
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 100 && got_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; auto_ready = 1'b0;
    req_valid = '0; req_pd = '0; req_atten = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (spi_valid !== 1'b0) begin errors++; $display("FAIL rst_spi_valid got %b want 0", spi_valid); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rst_req_ready got %b want 0000", req_ready); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got %b want 0", init_done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", busy); end
    checks++; if (shadow_atten !== {4{6'd32}}) begin errors++; $display("FAIL rst_shadow got %h want %h", shadow_atten, {4{6'd32}}); end
    got_q.delete();
    auto_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (spi_valid !== 1'b1 || spi_addr !== 2'd0 || spi_data !== 16'h0220) begin
      errors++; $display("FAIL init_first got v%b ch%0d %h want v1 ch0 0220", spi_valid, spi_addr, spi_data);
    end
    for (int c = 0; c < 40 && got_q.size() < 4; c++) begin
      @(negedge clk); #1;
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL init_req_ready got %b want 0000", req_ready); end
      checks++;
      if (init_done !== (got_q.size() >= 4)) begin
        errors++; $display("FAIL init_done_timing got %b after %0d words", init_done, got_q.size());
      end
    end
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL init_count got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), 16'h0220});
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [17:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL init_word got ch%0d %h want ch%0d %h", g[17:16], g[15:0], e[17:16], e[15:0]); end
    end
    exp_q.delete();
  endtask

  task automatic test_all_four();
    logic [17:0] e, g;
    int exp_gr[5];
    exp_gr = '{0, 1, 2, 3, 0};
    @(negedge clk);
    got_q.delete(); grant_q.delete();
    req_atten = {6'd4, 6'd3, 6'd2, 6'd1};
    req_pd    = '0;
    req_valid = 4'hF;
    for (int c = 0; c < 80 && grant_q.size() < 5; c++) @(negedge clk);
    req_valid = '0;
    wait_words(4);
    repeat (3) @(negedge clk);
    checks++; if (grant_q.size() != 5) begin errors++; $display("FAIL all4_grant_count got %0d want 5", grant_q.size()); end
    for (int i = 0; i < 5 && i < grant_q.size(); i++) begin
      checks++; if (grant_q[i] != exp_gr[i]) begin errors++; $display("FAIL all4_grant%0d got %0d want %0d", i, grant_q[i], exp_gr[i]); end
    end
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL all4_word_count got %0d want 4", got_q.size()); end
    exp_q.push_back({2'd0, 16'h0201}); exp_q.push_back({2'd1, 16'h0202});
    exp_q.push_back({2'd2, 16'h0203}); exp_q.push_back({2'd3, 16'h0204});
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL all4_word got ch%0d %h want ch%0d %h", g[17:16], g[15:0], e[17:16], e[15:0]); end
    end
    exp_q.delete();
    checks++; if (shadow_atten !== {6'd4, 6'd3, 6'd2, 6'd1}) begin errors++; $display("FAIL all4_shadow got %h want %h", shadow_atten, {6'd4, 6'd3, 6'd2, 6'd1}); end
  endtask

  task automatic test_single_ch2();
    bit ok;
    got_q.delete();
    do_req(2, 6'd10, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ch2_grant got none want req_ready[2]"); end
    wait_words(1);
    repeat (5) @(negedge clk);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL ch2_count got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== {2'd2, 16'h020A}) begin errors++; $display("FAIL ch2_word got ch%0d %h want ch2 020a", got_q[0][17:16], got_q[0][15:0]); end
    end
    checks++; if (shadow_atten !== {6'd4, 6'd10, 6'd2, 6'd1}) begin errors++; $display("FAIL ch2_shadow got %h want %h", shadow_atten, {6'd4, 6'd10, 6'd2, 6'd1}); end
  endtask

  task automatic test_clamp_pd();
    bit ok1, ok2;
    got_q.delete();
    do_req(1, 6'd45, 1'b0, ok1);
    wait_words(1);
    do_req(3, 6'd5, 1'b1, ok2);
    wait_words(2);
    repeat (3) @(negedge clk);
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL clamp_grants got %b%b want 11", ok1, ok2); end
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL clamp_count got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      checks++; if (got_q[0] !== {2'd1, 16'h0220}) begin errors++; $display("FAIL clamp_word got ch%0d %h want ch1 0220", got_q[0][17:16], got_q[0][15:0]); end
      checks++; if (got_q[1] !== {2'd3, 16'h0245}) begin errors++; $display("FAIL pd_word got ch%0d %h want ch3 0245", got_q[1][17:16], got_q[1][15:0]); end
    end
    checks++; if (shadow_atten !== {6'd5, 6'd10, 6'd32, 6'd1}) begin errors++; $display("FAIL clamp_shadow got %h want %h", shadow_atten, {6'd5, 6'd10, 6'd32, 6'd1}); end
  endtask

  task automatic test_redundant();
    bit ok;
    got_q.delete(); grant_q.delete();
    valid_cycles = 0;
    do_req(1, 6'd32, 1'b0, ok);
    repeat (4) @(negedge clk);
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL redund_grant got none want req_ready[1]"); end
    checks++; if (grant_q.size() != 1 || (grant_q.size() > 0 && grant_q[0] != 1)) begin
      errors++; $display("FAIL redund_grant_once got %0d grants want 1 on ch1", grant_q.size());
    end
    checks++; if (valid_cycles != 0) begin errors++; $display("FAIL redund_spi_valid got %0d cycles want 0", valid_cycles); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL redund_words got %0d want 0", got_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL idle_state got %0d want 1", dbg_state); end
  endtask

  task automatic test_reset_in_send();
    bit ok;
    auto_ready = 1'b0;
    got_q.delete();
    do_req(0, 6'd7, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL send_grant got none want req_ready[0]"); end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (spi_valid !== 1'b1 || spi_addr !== 2'd0 || spi_data !== 16'h0207) begin
      errors++; $display("FAIL send_hold got v%b ch%0d %h want v1 ch0 0207", spi_valid, spi_addr, spi_data);
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL send_no_ready got %0d words want 0", got_q.size()); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    checks++; if (spi_valid !== 1'b0) begin errors++; $display("FAIL midrst_spi_valid got %b want 0", spi_valid); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL midrst_init_done got %b want 0", init_done); end
    @(negedge clk);
    auto_ready = 1'b1;
    reset = 1'b0;
    #1;
    checks++;
    if (spi_valid !== 1'b1 || spi_addr !== 2'd0 || spi_data !== 16'h0220) begin
      errors++; $display("FAIL reinit_first got v%b ch%0d %h want v1 ch0 0220", spi_valid, spi_addr, spi_data);
    end
    wait_words(4);
    @(negedge clk); #1;
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL reinit_count got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== {2'(i), 16'h0220}) begin errors++; $display("FAIL reinit_word got ch%0d %h want ch%0d 0220", got_q[i][17:16], got_q[i][15:0], i); end
    end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL reinit_done got %b want 1", init_done); end
    checks++; if (shadow_atten !== {4{6'd32}}) begin errors++; $display("FAIL reinit_shadow got %h want %h", shadow_atten, {4{6'd32}}); end
  endtask

  initial begin
    test_reset();
    test_all_four();
    test_single_ch2();
    test_clamp_pd();
    test_redundant();
    test_reset_in_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
